// File: rtl/regfile_port_arbiter_pkg.sv
// Shared types and defaults for the register-file port arbiter.
package rf_arb_pkg;

  localparam int DEF_ADDR_W = 3;
  localparam int DEF_DATA_W = 16;

  // R0 is hardwired to zero, so writes to it are dropped at the arbiter.
  localparam int unsigned R0_IDX = 0;

  typedef enum logic [1:0] {
    ST_RUN       = 2'd0,
    ST_FORCE_DBG = 2'd1,
    ST_HALT      = 2'd2
  } arb_state_e;

  // Bits needed to hold a counter value in 0..limit.
  function automatic int cnt_width(input int limit);
    return (limit < 1) ? 1 : $clog2(limit + 1);
  endfunction

endpackage

// File: rtl/regfile_port_arbiter_if.sv
// Bundle of requester, response and register-file signals around the arbiter.
// slave is the arbiter's view; master is the surrounding requesters and RF.
interface regfile_port_arbiter_if
  import rf_arb_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
);

  logic              CoreReq;
  logic              CoreWe;
  logic [ADDR_W-1:0] CoreRAddr1;
  logic [ADDR_W-1:0] CoreRAddr2;
  logic [ADDR_W-1:0] CoreWAddr;
  logic [DATA_W-1:0] CoreWData;
  logic              CoreGnt;
  logic              CoreRspValid;
  logic [DATA_W-1:0] CoreRData1;
  logic [DATA_W-1:0] CoreRData2;

  logic              DbgReq;
  logic              DbgWe;
  logic [ADDR_W-1:0] DbgAddr;
  logic [DATA_W-1:0] DbgWData;
  logic              DbgHalt;
  logic              DbgGnt;
  logic              DbgRspValid;
  logic [DATA_W-1:0] DbgRData;
  logic              Halted;

  logic [ADDR_W-1:0] RfReadRegister1;
  logic [ADDR_W-1:0] RfReadRegister2;
  logic [ADDR_W-1:0] RfWriteRegister;
  logic [DATA_W-1:0] RfWriteData;
  logic              RfRegWrite;
  logic [DATA_W-1:0] RfReadData1;
  logic [DATA_W-1:0] RfReadData2;

  modport master (
    output CoreReq, CoreWe, CoreRAddr1, CoreRAddr2, CoreWAddr, CoreWData,
    output DbgReq, DbgWe, DbgAddr, DbgWData, DbgHalt,
    output RfReadData1, RfReadData2,
    input  CoreGnt, CoreRspValid, CoreRData1, CoreRData2,
    input  DbgGnt, DbgRspValid, DbgRData, Halted,
    input  RfReadRegister1, RfReadRegister2, RfWriteRegister, RfWriteData, RfRegWrite
  );

  modport slave (
    input  CoreReq, CoreWe, CoreRAddr1, CoreRAddr2, CoreWAddr, CoreWData,
    input  DbgReq, DbgWe, DbgAddr, DbgWData, DbgHalt,
    input  RfReadData1, RfReadData2,
    output CoreGnt, CoreRspValid, CoreRData1, CoreRData2,
    output DbgGnt, DbgRspValid, DbgRData, Halted,
    output RfReadRegister1, RfReadRegister2, RfWriteRegister, RfWriteData, RfRegWrite
  );

endinterface

// File: rtl/regfile_port_arbiter_starve_counter.sv
// Saturating count of consecutive cycles the debug port lost to the core.
// reached looks at the value being loaded this cycle, so the arbiter can
// switch priority in time for the very next cycle.
module starve_counter
  import rf_arb_pkg::*;
#(
  parameter int LIMIT = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic inc,
  input  logic clr,
  output logic reached
);

  localparam int              CNT_W   = cnt_width(LIMIT);
  localparam logic [CNT_W-1:0] LIMIT_C = CNT_W'(LIMIT);

  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] count_next;

  // Clear wins over increment; increment stops at the limit.
  always_comb begin
    count_next = count;
    if (clr) begin
      count_next = '0;
    end else if (inc && (count != LIMIT_C)) begin
      count_next = count + CNT_W'(1);
    end
  end

  // Counter register.
  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else begin
      count <= count_next;
    end
  end

  assign reached = (count_next == LIMIT_C);

endmodule

// File: rtl/regfile_port_arbiter.sv
// Arbitrates the single register file between the core and the debug port.
//
// state        | meaning
// ST_RUN       | core has priority, debug only on idle core cycles
// ST_FORCE_DBG | debug starved too long; debug has priority for one grant
// ST_HALT      | debug owns the register file, core is never granted
module regfile_port_arbiter
  import rf_arb_pkg::*;
#(
  parameter int ADDR_W       = DEF_ADDR_W,
  parameter int DATA_W       = DEF_DATA_W,
  parameter int STARVE_LIMIT = 4
) (
  input logic                   Clk,
  input logic                   Reset,
  regfile_port_arbiter_if.slave bus
);

  localparam logic [ADDR_W-1:0] R0 = ADDR_W'(R0_IDX);

  arb_state_e state;
  logic       halted_q;

  logic core_gnt;
  logic dbg_gnt;
  logic cnt_inc;
  logic cnt_clr;
  logic limit_hit;

  logic [ADDR_W-1:0] rd_reg1;
  logic [ADDR_W-1:0] rd_reg2;
  logic [ADDR_W-1:0] wr_reg;
  logic [DATA_W-1:0] wr_data;
  logic              wr_en;

  logic              core_valid_q;
  logic [DATA_W-1:0] core_rdata1_q;
  logic [DATA_W-1:0] core_rdata2_q;
  logic              dbg_valid_q;
  logic [DATA_W-1:0] dbg_rdata_q;

  // Zero-cycle grant decision from current requests and arbiter state.
  always_comb begin
    core_gnt = 1'b0;
    dbg_gnt  = 1'b0;
    if (!Reset) begin
      case (state)
        ST_RUN: begin
          core_gnt = bus.CoreReq;
          dbg_gnt  = bus.DbgReq && !bus.CoreReq;
        end
        ST_FORCE_DBG: begin
          dbg_gnt  = bus.DbgReq;
          core_gnt = bus.CoreReq && !bus.DbgReq;
        end
        ST_HALT: begin
          dbg_gnt  = bus.DbgReq;
        end
        default: begin
          core_gnt = 1'b0;
          dbg_gnt  = 1'b0;
        end
      endcase
    end
  end

  assign bus.CoreGnt = core_gnt;
  assign bus.DbgGnt  = dbg_gnt;

  // Debug loses a cycle only when it asked and the core was served instead.
  assign cnt_inc = bus.DbgReq && core_gnt;
  assign cnt_clr = dbg_gnt || !bus.DbgReq || ((state == ST_HALT) && !bus.DbgHalt);

  starve_counter #(
    .LIMIT (STARVE_LIMIT)
  ) u_starve (
    .clk     (Clk),
    .rst     (Reset),
    .inc     (cnt_inc),
    .clr     (cnt_clr),
    .reached (limit_hit)
  );

  // Arbiter state machine; Halted is registered alongside the state.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state    <= ST_RUN;
      halted_q <= 1'b0;
    end else if (bus.DbgHalt) begin
      state    <= ST_HALT;
      halted_q <= 1'b1;
    end else begin
      halted_q <= 1'b0;
      case (state)
        ST_RUN: begin
          if (limit_hit) state <= ST_FORCE_DBG;
        end
        ST_FORCE_DBG: begin
          if (dbg_gnt || !bus.DbgReq) state <= ST_RUN;
        end
        ST_HALT: begin
          state <= ST_RUN;
        end
        default: begin
          state <= ST_RUN;
        end
      endcase
    end
  end

  assign bus.Halted = halted_q;

  // Steer the winner onto the register-file ports; idle cycles drive zeros.
  always_comb begin
    rd_reg1 = '0;
    rd_reg2 = '0;
    wr_reg  = '0;
    wr_data = '0;
    wr_en   = 1'b0;
    if (core_gnt) begin
      if (bus.CoreWe) begin
        wr_reg  = bus.CoreWAddr;
        wr_data = bus.CoreWData;
        wr_en   = (bus.CoreWAddr != R0);
      end else begin
        rd_reg1 = bus.CoreRAddr1;
        rd_reg2 = bus.CoreRAddr2;
      end
    end else if (dbg_gnt) begin
      if (bus.DbgWe) begin
        wr_reg  = bus.DbgAddr;
        wr_data = bus.DbgWData;
        wr_en   = (bus.DbgAddr != R0);
      end else begin
        rd_reg1 = bus.DbgAddr;
        rd_reg2 = bus.DbgAddr;
      end
    end
  end

  assign bus.RfReadRegister1 = rd_reg1;
  assign bus.RfReadRegister2 = rd_reg2;
  assign bus.RfWriteRegister = wr_reg;
  assign bus.RfWriteData     = wr_data;
  assign bus.RfRegWrite      = wr_en;

  // Capture read data sampled by the RF on the falling edge of the grant cycle.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      core_valid_q  <= 1'b0;
      core_rdata1_q <= '0;
      core_rdata2_q <= '0;
      dbg_valid_q   <= 1'b0;
      dbg_rdata_q   <= '0;
    end else begin
      core_valid_q <= core_gnt && !bus.CoreWe;
      dbg_valid_q  <= dbg_gnt && !bus.DbgWe;
      if (core_gnt && !bus.CoreWe) begin
        core_rdata1_q <= bus.RfReadData1;
        core_rdata2_q <= bus.RfReadData2;
      end
      if (dbg_gnt && !bus.DbgWe) begin
        dbg_rdata_q <= bus.RfReadData1;
      end
    end
  end

  // A reset landing in the response cycle cancels the pulse immediately.
  assign bus.CoreRspValid = core_valid_q && !Reset;
  assign bus.DbgRspValid  = dbg_valid_q && !Reset;
  assign bus.CoreRData1   = core_rdata1_q;
  assign bus.CoreRData2   = core_rdata2_q;
  assign bus.DbgRData     = dbg_rdata_q;

endmodule
